counter_scheduler: RTL
======================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and length width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2 bits, count-session requests; bit 0 is requester 1 and bit 1 is requester 2.
REQ-005 The block SHALL have port len1, input, WIDTH bits, the terminal count for requester 1's session.
REQ-006 The block SHALL have port len2, input, WIDTH bits, the terminal count for requester 2's session.
REQ-007 The block SHALL have port abort, input, 1 bit, which terminates the active session.
REQ-008 The block SHALL have port gnt, output, 2 bits, a one-hot registered grant.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 2 bits, a one-cycle completion pulse per requester.
REQ-011 The block SHALL have port counter1, output, WIDTH bits, requester 1's session counter.
REQ-012 The block SHALL have port counter2, output, WIDTH bits, requester 2's session counter.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-014 In IDLE with req nonzero at edge N, the FSM SHALL do the following at edge N:
- select the winner (REQ-015);
- latch the winner's len into len_q;
- clear the winner's counter to 0;
- set gnt to the winner;
- enter RUN.
REQ-015 Arbitration SHALL behave as follows:
- a single request wins;
- when both request, the requester not served last wins (round-robin).
REQ-016 In RUN, each edge SHALL behave as follows:
- if the granted counter equals len_q, enter DONE with the counter held;
- otherwise, increment the granted counter by 1.
REQ-017 A session with len_q=L SHALL occupy exactly L+1 RUN cycles; L=0 gives one RUN cycle with the counter at 0.
REQ-018 The counter SHALL never wrap, because len_q is at most 2^WIDTH-1; L=15 ends at 15.
REQ-019 In DONE, the block SHALL behave as follows:
- done[g] is 1 for exactly one cycle;
- gnt is 0;
- the last-served pointer becomes g;
- the next state is IDLE.
REQ-020 The earliest following grant SHALL be the edge after the IDLE cycle that follows DONE.
REQ-021 abort sampled high in RUN SHALL behave as follows:
- next state is IDLE;
- gnt is cleared;
- no done pulse is generated;
- the counter holds its current value;
- the last-served pointer is updated to the aborted requester.
REQ-022 abort SHALL have no effect in IDLE or DONE.
REQ-023 Sessions SHALL be non-preemptive: req changes and len1/len2 changes during RUN are ignored.
REQ-024 The counter of the non-granted requester SHALL hold its last value.
REQ-025 If abort and the terminal condition coincide in RUN, abort SHALL win: no done pulse.

Reset
REQ-026 With reset low at a rising edge, the block SHALL behave as follows:
- state is IDLE;
- gnt, done, busy, counter1, counter2 and len_q are all 0;
- the last-served pointer is set so requester 1 wins the first tie.
REQ-027 Reset SHALL dominate req and abort, including mid-RUN and mid-DONE; no done pulse is emitted.
REQ-028 Reset SHALL have no asynchronous effect: outputs change only at clk edges.

Configuration
REQ-029 Macro COUNTER_SCHED_FIXED_PRIO_EN SHALL select the arbitration mode as follows:
- when defined, requester 1 always wins a tie, and the last-served pointer is unused;
- when undefined, arbitration is round-robin per REQ-015;
- all other behaviour is identical in both modes.

Verification
REQ-030 Single session: req=01 and len1=3 -> gnt=01 next edge, then counter1 runs 0,1,2,3 over 4 RUN cycles, then done=01 for 1 cycle, then busy=0.
REQ-031 Tie round-robin: req=11 held continuously after reset with len1=len2=1 -> grants alternate 01,10,01. With COUNTER_SCHED_FIXED_PRIO_EN defined -> grants are always 01.
REQ-032 Zero length: len2=0 and req=10 -> 1 RUN cycle with counter2=0, then done=10.
REQ-033 Abort: len1=10 and abort pulsed when counter1=4 -> IDLE next edge, counter1 holds 4, no done pulse, next tie goes to requester 2.
REQ-034 Reset mid-RUN: reset low when counter2=6 -> all outputs 0 at that edge, no done pulse, and the first tie after reset goes to requester 1.
REQ-035 Max length and ignored inputs: len1=15, with len1 changed to 2 mid-RUN -> counter1 reaches 15 without wrap, 16 RUN cycles, done=01.

Source files
------------

// File: rtl/counter_scheduler.sv
// Two-requester count-session scheduler: grants one requester at a time and runs its counter up to a latched length.
// Define COUNTER_SCHED_FIXED_PRIO_EN to make requester 1 always win a tie; the default build arbitrates ties round-robin.
module counter_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] len2,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] counter1,
  output logic [WIDTH-1:0] counter2
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt1_q, cnt1_d;
  logic [WIDTH-1:0] cnt2_q, cnt2_d;
  // last_q = 1 means requester 2 was served last, so requester 1 wins the next tie.
  logic             last_q, last_d;

  logic [1:0]       win;
  logic [WIDTH-1:0] cur_cnt;
  logic             at_end;

  always_comb begin
    win = req;
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    if (req == 2'b11) win = 2'b01;
`else
    if (req == 2'b11) win = last_q ? 2'b01 : 2'b10;
`endif
  end

  assign cur_cnt = gnt_q[1] ? cnt2_q : cnt1_q;
  assign at_end  = (cur_cnt == len_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    len_d   = len_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = RUN;
          gnt_d   = win;
          len_d   = win[0] ? len1 : len2;
          if (win[0]) cnt1_d = '0;
          else        cnt2_d = '0;
        end
      end
      RUN: begin
        // Abort takes priority over the terminal count, so a coinciding end emits no done.
        if (abort) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          last_d  = gnt_q[1];
        end else if (at_end) begin
          state_d = DONE;
          gnt_d   = 2'b00;
          done_d  = gnt_q;
        end else if (gnt_q[1]) begin
          cnt2_d = cnt2_q + WIDTH'(1);
        end else begin
          cnt1_d = cnt1_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = done_q[1];
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      len_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      last_q  <= last_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign counter1 = cnt1_q;
  assign counter2 = cnt2_q;

endmodule
